sincos_table_loader: RTL and testbench
======================================

Name: sincos_table_loader

Overview:
- Upstream stage of the phase-counter / sine-cosine lookup block. Owns write port 0 of both 32x512 lookup SRAMs and the shared read-enable (csb1).
- Accepts a valid/ready stream of (sine, cosine) word pairs. Writes them to consecutive SRAM addresses starting at a programmable base.
- Holds the lookup read port disabled for the whole load, then re-enables it and pulses done.

Parameters:
- ADDR_W, 9, SRAM address width; table depth is 2^ADDR_W.
- DATA_W, 32, width of each sine and cosine word.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; captured on an accepted start.
- word_count  in  ADDR_W+1  number of pairs to write (1..512); captured on an accepted start.
- s_valid  in  1  upstream pair valid.
- s_ready  out  1  loader can accept a pair this cycle.
- s_sin  in  DATA_W  sine word.
- s_cos  in  DATA_W  cosine word.
- csb0  out  1  SRAM port-0 chip select, active low.
- web0  out  1  SRAM port-0 write enable, active low.
- wmask0  out  4  byte write mask.
- addr0  out  ADDR_W  SRAM port-0 address.
- din00  out  DATA_W  sine SRAM write data.
- din01  out  DATA_W  cosine SRAM write data.
- csb1  out  1  shared read-port chip select for both SRAMs, active low.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- All outputs are registered.
- Reset values (reset_n=0, asynchronous): csb0=1, web0=1, wmask0=0, addr0=0, din00=0, din01=0, csb1=1, s_ready=0, busy=0, done=0, err=0; state=IDLE.
- FSM states: IDLE, ARM, LOAD, DRAIN, FIN.
- IDLE:
  - csb1=0 from the first clock after reset.
  - start=1 with word_count in 1..512: capture base_addr into a write pointer and word_count into a remaining counter; go to ARM.
  - start=1 with word_count=0 or >512: err=1 for one cycle; stay in IDLE; no SRAM activity.
- ARM (exactly 1 cycle): csb1=1, busy=1, s_ready=0. This guard cycle lets any in-flight read finish. Then go to LOAD.
- LOAD: s_ready=1 while remaining>0.
  - Transfer: s_valid && s_ready at an edge. That same edge registers csb0=0, web0=0, wmask0=4'hF, addr0=pointer, din00=s_sin, din01=s_cos.
  - After a transfer, pointer increments modulo 2^ADDR_W (511 wraps to 0) and remaining decrements.
  - Cycles with no transfer register csb0=1, web0=1. Bubbles are allowed.
  - The transfer that makes remaining=0 moves the FSM to DRAIN. s_ready drops to 0 on that same edge.
- DRAIN (1 cycle): the final write strobe is presented. Next edge registers csb0=1, web0=1; go to FIN.
- FIN (1 cycle): done=1, busy=1, csb1 still 1. Next edge: IDLE, busy=0, csb1=0.
- busy=1 in ARM, LOAD, DRAIN and FIN.
- Latency:
  - csb1 rises one cycle after start is accepted.
  - First possible accept is 2 cycles after start.
  - For N back-to-back pairs, done asserts N+3 cycles after start; csb1 returns low at N+4.
- start while busy is ignored, with no err pulse.
- s_valid and data are ignored whenever s_ready=0.
- reset_n asserted mid-load: immediate return to reset values, so no further write strobes are issued. The table is left partially written; no recovery is attempted.
- Write strobes (csb0=0) never coincide with csb1=0.

Test Plan:
- Basic load:
  - Stimulus: reset, start with base=0, count=4, then pairs (1,101), (2,102), (3,103), (4,104) back-to-back.
  - Required response: writes at addr0=0..3 with matching din00/din01 and wmask0=F; done pulse at cycle 7 after start; csb1 low again at cycle 8.
- Wrap-around:
  - Stimulus: base=510, count=4.
  - Required response: addr0 sequence 510, 511, 0, 1.
- Throttled upstream:
  - Stimulus: count=3, s_valid toggling 1,0,0,1,0,1.
  - Required response: exactly 3 write strobes, with csb0=1 on bubble cycles; done 2 cycles after the last accept.
- Invalid starts:
  - Stimulus: start with count=0; separately, start pulsed again mid-load.
  - Required response: err pulse with busy staying 0 for count=0; the mid-load start has no effect and gives no err.
- Reset mid-load:
  - Stimulus: count=8, reset_n low after the 3rd accept.
  - Required response: csb0=1, web0=1, csb1=1, busy=0 immediately; after release, csb1=0 on the next clock.
- Full table:
  - Stimulus: count=512 with base=5.
  - Required response: 512 writes, the last at addr0=4; s_ready=0 after the 512th accept.
  - Invariant checked for every test: csb0=0 never coincides with csb1=0.

Source files
------------

// File: rtl/sincos_table_loader.sv
// ---------------------------------------------------------------------------
// sincos_table_loader
//
// Upstream loader for the sine/cosine lookup tables. It owns write port 0 of
// both lookup SRAMs (sine and cosine share address, strobes and mask) and the
// shared read-port chip select. A load takes a valid/ready stream of
// (sine, cosine) pairs and writes them to consecutive addresses starting at a
// programmable base, wrapping at the top of the table. The read port is
// disabled for the whole load and re-enabled once it finishes.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               begin a load (only honoured when idle)
//   base_addr           first write address, captured on accepted start
//   word_count          number of pairs (1..2^ADDR_W), captured on start
//   s_valid/s_ready     upstream handshake
//   s_sin, s_cos        sine / cosine words of the current pair
//   csb0, web0, wmask0  SRAM port-0 chip select, write enable, byte mask
//   addr0               SRAM port-0 address
//   din00, din01        sine / cosine SRAM write data
//   csb1                shared read-port chip select (active low)
//   busy                load in progress
//   done                one-cycle pulse at load completion
//   err                 one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module sincos_table_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_sin,
  input  logic [DATA_W-1:0] s_cos,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din00,
  output logic [DATA_W-1:0] din01,
  output logic              csb1,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ARM, LOAD, DRAIN, FIN} state_t;

  // Largest legal count is the full table depth.
  localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   remaining;
  logic              transfer;

  // s_ready is registered and only ever high in LOAD, so this is the
  // handshake as seen at the coming edge.
  assign transfer = (state == LOAD) && s_valid && s_ready;

  // Single state machine; every output is a register updated here. The write
  // pointer is ADDR_W bits wide so incrementing past the top wraps to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      s_ready   <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= 4'h0;
      addr0     <= '0;
      din00     <= '0;
      din01     <= '0;
      csb1      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          csb0   <= 1'b1;
          web0   <= 1'b1;
          wmask0 <= 4'h0;
          csb1   <= 1'b0;
          if (start) begin
            if ((word_count != '0) && (word_count <= MAX_COUNT)) begin
              wr_ptr    <= base_addr;
              remaining <= word_count;
              csb1      <= 1'b1;
              busy      <= 1'b1;
              state     <= ARM;
            end else begin
              err <= 1'b1;
            end
          end
        end

        // Guard cycle: read port already disabled, lets an in-flight read
        // complete before the first write can land.
        ARM: begin
          s_ready <= 1'b1;
          state   <= LOAD;
        end

        LOAD: begin
          if (transfer) begin
            csb0      <= 1'b0;
            web0      <= 1'b0;
            wmask0    <= 4'hF;
            addr0     <= wr_ptr;
            din00     <= s_sin;
            din01     <= s_cos;
            wr_ptr    <= wr_ptr + ONE_ADDR;
            remaining <= remaining - ONE_CNT;
            if (remaining == ONE_CNT) begin
              s_ready <= 1'b0;
              state   <= DRAIN;
            end
          end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= 4'h0;
          end
        end

        // The final write strobe is on the outputs during this cycle.
        DRAIN: begin
          csb0   <= 1'b1;
          web0   <= 1'b1;
          wmask0 <= 4'h0;
          done   <= 1'b1;
          state  <= FIN;
        end

        FIN: begin
          busy  <= 1'b0;
          csb1  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_table_loader.sv
// ---------------------------------------------------------------------------
// tb_sincos_table_loader
//
// Directed bench for sincos_table_loader. Each scenario task drives its own
// stimulus and compares outputs one time unit after the rising edge. A
// background monitor flags any cycle where a write strobe overlaps an
// enabled read port.
// ---------------------------------------------------------------------------
module tb_sincos_table_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  word_count;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_sin;
  logic [31:0] s_cos;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din00;
  logic [31:0] din01;
  logic        csb1;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  sincos_table_loader #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_ready(s_ready),
    .s_sin(s_sin), .s_cos(s_cos), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din00(din00), .din01(din01), .csb1(csb1), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write strobe must never overlap an enabled read port.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (csb0 === 1'b0 && csb1 === 1'b0) begin
        errors++;
        $display("[TB] FAIL invariant: csb0=%b csb1=%b required not both 0 at %0t", csb0, csb1, $time);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({csb0, web0, wmask0, addr0, din00, din01, csb1, s_ready, busy, done, err} !==
        {1'b1, 1'b1, 4'h0, 9'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: csb0=%b web0=%b wmask0=%h addr0=%0d din00=%h din01=%h csb1=%b s_ready=%b busy=%b done=%b err=%b required 1 1 0 0 0 0 1 0 0 0 0",
               csb0, web0, wmask0, addr0, din00, din01, csb1, s_ready, busy, done, err);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (csb1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_csb1_release: got %b required 0", csb1);
    end
  endtask

  task automatic test_basic_load;
    // cycle 0: start, with junk upstream data that must be ignored
    start = 1'b1; base_addr = 9'd0; word_count = 10'd4;
    s_valid = 1'b1; s_sin = 32'd99; s_cos = 32'd999;
    tick();
    start = 1'b0;
    checks++;
    if ({csb1, busy, s_ready, csb0} !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL basic_arm: csb1/busy/s_ready/csb0=%b required 1101", {csb1, busy, s_ready, csb0});
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      s_sin = 32'(k + 1);
      s_cos = 32'(101 + k);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_ready%0d: got %b required 1", k, s_ready);
      end
      tick();
      checks++;
      if ({csb0, web0, wmask0} !== 6'b00_1111 || addr0 !== 9'(k) ||
          din00 !== 32'(k + 1) || din01 !== 32'(101 + k)) begin
        errors++;
        $display("[TB] FAIL basic_write%0d: csb0=%b web0=%b wmask0=%h addr0=%0d din00=%0d din01=%0d required 0 0 f %0d %0d %0d",
                 k, csb0, web0, wmask0, addr0, din00, din01, k, k + 1, 101 + k);
      end
    end
    // cycle 6 (DRAIN): junk with s_valid high must not be written
    s_sin = 32'd77; s_cos = 32'd777;
    checks++;
    if (s_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_drain: s_ready=%b done=%b required 0 0", s_ready, done);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if ({done, busy, csb1, csb0, web0} !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL basic_done_cycle7: done/busy/csb1/csb0/web0=%b required 11111", {done, busy, csb1, csb0, web0});
    end
    tick();
    checks++;
    if ({done, busy, csb1} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL basic_idle_cycle8: done/busy/csb1=%b required 000", {done, busy, csb1});
    end
  endtask

  task automatic test_wrap;
    logic [8:0] exp_addr;
    exp_addr = 9'd510;
    start = 1'b1; base_addr = 9'd510; word_count = 10'd4;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_sin = 32'h100 + 32'(k);
      s_cos = 32'h200 + 32'(k);
      tick();
      checks++;
      if (csb0 !== 1'b0 || addr0 !== exp_addr || din00 !== 32'h100 + 32'(k)) begin
        errors++;
        $display("[TB] FAIL wrap_addr%0d: csb0=%b addr0=%0d din00=%h required 0 %0d %h",
                 k, csb0, addr0, din00, exp_addr, 32'h100 + 32'(k));
      end
      exp_addr = exp_addr + 9'd1;
    end
    s_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, csb1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wrap_end: busy/csb1=%b required 00", {busy, csb1});
    end
  endtask

  task automatic test_throttle;
    logic [5:0] pattern;
    logic [8:0] exp_addr;
    int strobes;
    pattern = 6'b101001;
    exp_addr = 9'd100;
    strobes = 0;
    start = 1'b1; base_addr = 9'd100; word_count = 10'd3;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      s_valid = pattern[i];
      s_sin = 32'(40 + i);
      s_cos = 32'(80 + i);
      tick();
      checks++;
      if (csb0 !== ~pattern[i] || web0 !== ~pattern[i]) begin
        errors++;
        $display("[TB] FAIL throttle_strobe%0d: csb0=%b web0=%b required %b", i, csb0, web0, ~pattern[i]);
      end
      if (csb0 === 1'b0) begin
        strobes++;
        checks++;
        if (addr0 !== exp_addr || din00 !== 32'(40 + i) || din01 !== 32'(80 + i)) begin
          errors++;
          $display("[TB] FAIL throttle_data%0d: addr0=%0d din00=%0d din01=%0d required %0d %0d %0d",
                   i, addr0, din00, din01, exp_addr, 40 + i, 80 + i);
        end
        exp_addr = exp_addr + 9'd1;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (strobes !== 3 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL throttle_count: strobes=%0d done=%b required 3 0", strobes, done);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL throttle_done: got %b required 1", done);
    end
    tick();
  endtask

  task automatic test_invalid_start;
    start = 1'b1; word_count = 10'd0; base_addr = 9'd3;
    tick();
    start = 1'b0;
    checks++;
    if ({err, busy, csb1, csb0} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL invalid_zero: err/busy/csb1/csb0=%b required 1001", {err, busy, csb1, csb0});
    end
    tick();
    checks++;
    if ({err, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL invalid_zero_after: err/busy=%b required 00", {err, busy});
    end
    start = 1'b1; word_count = 10'd513;
    tick();
    start = 1'b0;
    checks++;
    if ({err, busy, csb1} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL invalid_513: err/busy/csb1=%b required 100", {err, busy, csb1});
    end
    // Valid two-pair load with starts pulsed while busy.
    start = 1'b1; word_count = 10'd2; base_addr = 9'd7;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; word_count = 10'd5; base_addr = 9'd300;
    s_valid = 1'b1; s_sin = 32'hA; s_cos = 32'hB;
    tick();
    word_count = 10'd0;
    s_sin = 32'hC; s_cos = 32'hD;
    checks++;
    if (err !== 1'b0 || csb0 !== 1'b0 || addr0 !== 9'd7) begin
      errors++;
      $display("[TB] FAIL midstart_w0: err=%b csb0=%b addr0=%0d required 0 0 7", err, csb0, addr0);
    end
    tick();
    start = 1'b0;
    s_valid = 1'b0;
    checks++;
    if (err !== 1'b0 || csb0 !== 1'b0 || addr0 !== 9'd8 || din00 !== 32'hC || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midstart_w1: err=%b csb0=%b addr0=%0d din00=%h s_ready=%b required 0 0 8 c 0",
               err, csb0, addr0, din00, s_ready);
    end
    tick();
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midstart_done: done/err=%b required 10", {done, err});
    end
    tick();
    checks++;
    if ({busy, csb1, err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midstart_idle: busy/csb1/err=%b required 000", {busy, csb1, err});
    end
  endtask

  task automatic test_reset_midload;
    start = 1'b1; base_addr = 9'd20; word_count = 10'd8;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_sin = 32'(k); s_cos = 32'(k);
      tick();
    end
    checks++;
    if (csb0 !== 1'b0 || addr0 !== 9'd22) begin
      errors++;
      $display("[TB] FAIL rstmid_third: csb0=%b addr0=%0d required 0 22", csb0, addr0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({csb0, web0, csb1, busy, s_ready} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL rstmid_async: csb0/web0/csb1/busy/s_ready=%b required 11100", {csb0, web0, csb1, busy, s_ready});
    end
    tick();
    reset_n = 1'b1;
    s_valid = 1'b0;
    checks++;
    if ({csb1, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rstmid_release: csb1/busy=%b required 10", {csb1, busy});
    end
    tick();
    checks++;
    if ({csb1, csb0, busy} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL rstmid_idle: csb1/csb0/busy=%b required 010", {csb1, csb0, busy});
    end
  endtask

  task automatic test_full_table;
    logic [8:0] exp_addr;
    int bad;
    exp_addr = 9'd5;
    bad = 0;
    start = 1'b1; base_addr = 9'd5; word_count = 10'd512;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1;
    for (int k = 0; k < 512; k++) begin
      s_sin = 32'(k);
      s_cos = ~32'(k);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 5) $display("[TB] FAIL full_ready%0d: got %b required 1", k, s_ready);
      end
      tick();
      checks++;
      if (csb0 !== 1'b0 || addr0 !== exp_addr || din00 !== 32'(k) || din01 !== ~32'(k)) begin
        errors++;
        bad++;
        if (bad < 5) $display("[TB] FAIL full_write%0d: csb0=%b addr0=%0d din00=%h required 0 %0d %h",
                              k, csb0, addr0, din00, exp_addr, 32'(k));
      end
      exp_addr = exp_addr + 9'd1;
    end
    checks++;
    if (s_ready !== 1'b0 || addr0 !== 9'd4) begin
      errors++;
      $display("[TB] FAIL full_last: s_ready=%b addr0=%0d required 0 4", s_ready, addr0);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if ({done, csb0} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL full_done: done/csb0=%b required 11", {done, csb0});
    end
    tick();
    checks++;
    if ({busy, csb1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL full_idle: busy/csb1=%b required 00", {busy, csb1});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    s_valid = 1'b0;
    s_sin = '0;
    s_cos = '0;
    test_reset();
    test_basic_load();
    test_wrap();
    test_throttle();
    test_invalid_start();
    test_reset_midload();
    test_full_table();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
